// File: rtl/trigout_ts_fifo.sv
// trigout_ts_fifo: rising-edge trigger timestamper feeding a first-word-fall-through event FIFO
// Optional holdoff build macro: TRIGOUT_DEADTIME_EN (adds deadtime_i and a holdoff counter)
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   trig_i, ext_trig_i            channel / external trigger levels
//   ch_enable_i, ext_enable_i     per-source capture enables
//   ts_sec_i, ts_cycles_i         White Rabbit time, wr_valid_i qualifies it
//   pop_i                         discard head entry, clr_i clears overflow accounting
//   ts_present_o                  head valid; mask_o/sec_o/cycles_o/time_valid_o are the head entry
//   count_o, full_o               occupancy and full flag
//   overflow_o, ovf_cnt_o         sticky drop flag and saturating drop counter
//   deadtime_i                    (TRIGOUT_DEADTIME_EN only) holdoff length in cycles
module trigout_ts_fifo #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH-1:0]          trig_i,
    input  logic                       ext_trig_i,
    input  logic [NUM_CH-1:0]          ch_enable_i,
    input  logic                       ext_enable_i,
    input  logic [39:0]                ts_sec_i,
    input  logic [27:0]                ts_cycles_i,
    input  logic                       wr_valid_i,
    input  logic                       pop_i,
    input  logic                       clr_i,
`ifdef TRIGOUT_DEADTIME_EN
    input  logic [15:0]                deadtime_i,
`endif
    output logic                       ts_present_o,
    output logic [NUM_CH:0]            mask_o,
    output logic [39:0]                sec_o,
    output logic [27:0]                cycles_o,
    output logic                       time_valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic [CNT_W-1:0]           ovf_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = NUM_CH + 1 + 40 + 28 + 1;
    logic [NUM_CH:0] prev, raw, rise;
    logic            ev_valid;
    logic [EW-1:0]   ev, head, head_n;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr, rptr, rptr_n;
    logic [CW-1:0]   count, count_n;
    logic            do_pop, do_push, drop;
    assign raw = {ext_trig_i, trig_i} & ~prev & {ext_enable_i, ch_enable_i};
`ifdef TRIGOUT_DEADTIME_EN
    logic [15:0] dt;
    // rises are suppressed while the holdoff counter runs; history still tracks levels
    assign rise = (dt == 16'd0) ? raw : '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            dt <= '0;
        else
            dt <= (|rise) ? deadtime_i : (dt != 16'd0) ? dt - 16'd1 : dt;
    end
`else
    assign rise = raw;
`endif
    // a pop on an empty FIFO is ignored even when a push lands in the same cycle
    assign do_pop  = pop_i & ts_present_o;
    assign do_push = ev_valid & (~full_o | do_pop);
    assign drop    = ev_valid & ~do_push;
    assign rptr_n  = rptr + AW'(do_pop);
    assign count_n = count + CW'(do_push) - CW'(do_pop);
    // head is registered so it holds its last value once the FIFO drains;
    // an entry pushed into an empty (or emptying) FIFO bypasses the memory
    assign head_n = (do_push && count == CW'(do_pop)) ? ev :
                    (count_n != '0) ? mem[rptr_n] : head;
    always_ff @(posedge clk_i) begin
        if (do_push)
            mem[wptr] <= ev;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev         <= '0;
            ev_valid     <= 1'b0;
            ev           <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            ts_present_o <= 1'b0;
            full_o       <= 1'b0;
            head         <= '0;
            overflow_o   <= 1'b0;
            ovf_cnt_o    <= '0;
        end else begin
            prev         <= {ext_trig_i, trig_i};
            ev_valid     <= |rise;
            ev           <= {rise, ts_sec_i, ts_cycles_i, wr_valid_i};
            wptr         <= wptr + AW'(do_push);
            rptr         <= rptr_n;
            count        <= count_n;
            ts_present_o <= count_n != '0;
            full_o       <= count_n == CW'(DEPTH);
            head         <= head_n;
            // a drop in the same cycle as clr_i wins and restarts the count at 1
            overflow_o   <= drop | (overflow_o & ~clr_i);
            ovf_cnt_o    <= drop ? (clr_i ? CNT_W'(1) : (&ovf_cnt_o) ? ovf_cnt_o : ovf_cnt_o + 1'b1) :
                            clr_i ? '0 : ovf_cnt_o;
        end
    end
    assign {mask_o, sec_o, cycles_o, time_valid_o} = head;
    assign count_o = count;
endmodule

// File: doc/trigout_ts_fifo.md
Name: trigout_ts_fifo

Overview:
- Parametrised successor of the alternate trigger-output timestamp unit.
- Detects rising edges on NUM_CH ADC channel triggers plus one external trigger and timestamps each event with White Rabbit time (40-bit seconds, 28-bit cycles).
- Queues events in a DEPTH-entry first-word-fall-through FIFO, with occupancy, overflow accounting and pop-on-read.
- Sits between the trigger logic and the CSR block; the CSR read of the cycles word drives pop_i.

Parameters:
- NUM_CH, 4, number of channel trigger inputs (1..16).
- DEPTH, 16, FIFO entries; power of two, 2..256.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- trig_i  in  NUM_CH  channel trigger levels, synchronous to clk_i.
- ext_trig_i  in  1  external trigger level, synchronous.
- ch_enable_i  in  NUM_CH  per-channel capture enable.
- ext_enable_i  in  1  external capture enable.
- ts_sec_i  in  40  WR seconds.
- ts_cycles_i  in  28  WR cycles.
- wr_valid_i  in  1  WR time valid.
- pop_i  in  1  discard head entry.
- clr_i  in  1  clear overflow flag and counter.
- ts_present_o  out  1  FIFO not empty (head valid).
- mask_o  out  NUM_CH+1  head trigger mask; bit NUM_CH is external.
- sec_o  out  40  head seconds.
- cycles_o  out  28  head cycles.
- time_valid_o  out  1  head captured with wr_valid_i=1.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- full_o  out  1  count_o==DEPTH.
- overflow_o  out  1  sticky: an event was dropped.
- ovf_cnt_o  out  CNT_W  dropped events, saturating.

Behaviour:
- Reset: all outputs 0, FIFO empty, edge-detect history registers = 0.
- Edge detect: per input, rise = level & ~prev & enable, registered each cycle. A trigger already high at reset release therefore produces a rise on the first cycle.
- Event: any rise bit set in cycle N. The entry holds:
  - mask = all rise bits of cycle N;
  - sec/cycles = ts_sec_i/ts_cycles_i sampled in cycle N;
  - time_valid = wr_valid_i in cycle N.
- Coincident rises merge into one entry; they are never split.
- Push: the entry is written at the end of cycle N+1. It is visible on the head outputs with ts_present_o=1 from cycle N+2 when the FIFO was empty.
- Pop: pop_i with ts_present_o=1 advances the head; the new head or empty state is visible the next cycle. pop_i while empty is ignored: no underflow, count stays 0.
- Simultaneous push and pop:
  - not full: count unchanged;
  - full: pop frees the slot and the push succeeds, no overflow;
  - empty with push pending: the pop is ignored and the push lands.
- Full without pop:
  - the event is dropped and the FIFO contents are unchanged;
  - overflow_o is set to 1;
  - ovf_cnt_o increments and saturates at 2^CNT_W-1.
- clr_i: overflow_o and ovf_cnt_o go to 0 next cycle. If a drop occurs in the same cycle, the drop wins: flag = 1, count = 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked separately so that full and empty are unambiguous.
- The head outputs hold their last value when empty; only ts_present_o qualifies them.
- Reset mid-operation: everything clears immediately (asynchronous reset), and pending events are lost.
- count_o, full_o and ts_present_o are registered, updated in the same cycle as the storage.

Optional Feature:
- Macro: TRIGOUT_DEADTIME_EN.
- When defined:
  - adds input deadtime_i[15:0];
  - after each accepted or dropped event, further rises are ignored for deadtime_i clock cycles;
  - the counter loads on the event cycle; deadtime_i=0 means no holdoff;
  - ignored rises neither count as overflow nor update the history beyond normal edge tracking.
- When undefined: no port and no counter; every rise is an event.

Test Plan:
- Rise on trig_i[2] with ts_sec=0x12_3456_789A, cycles=0x0ABCDEF, wr_valid=1 -> two cycles later ts_present_o=1, mask_o=0b00100, sec/cycles match, time_valid_o=1, count_o=1.
- trig_i[0], trig_i[3] and ext_trig_i rise in the same cycle with all enables set -> single entry, mask_o=0b11001, count_o=1. Same with ch_enable_i[3]=0 -> mask_o=0b10001.
- Push DEPTH+3 events spaced 2 cycles apart with no pops -> full_o=1, count_o=DEPTH, overflow_o=1, ovf_cnt_o=3; the head is still the first event. clr_i -> overflow_o=0, ovf_cnt_o=0.
- Full FIFO, then pop_i and a new event in the same cycle -> count_o stays DEPTH, no overflow increment. Draining all entries returns them in order, including the new one last.
- pop_i on an empty FIFO for 5 cycles -> count_o=0 and ts_present_o=0 throughout. A subsequent event is read back correctly.
- With TRIGOUT_DEADTIME_EN, deadtime_i=10 and rises at cycles 0, 5 and 12 -> entries only for cycles 0 and 12. With deadtime_i=0 -> three entries.
